// File: rtl/alu_pkg.sv
// Shared ALU-side definitions: shift op encodings, the entry carried through the
// operand stage, and the shift encoding legality check.
package alu_pkg;

    localparam logic [1:0] SHIFT_SLL  = 2'b00;
    localparam logic [1:0] SHIFT_SRL  = 2'b01;
    localparam logic [1:0] SHIFT_SRA  = 2'b11;
    localparam logic [6:0] FUNCT7_SRA = 7'b0100000;

    typedef struct packed {
        logic [31:0] op1;
        logic [4:0]  shamt;
        logic [1:0]  op;
        logic [4:0]  rd;
        logic        illegal;
    } shift_entry_t;

    // Immediate forms carry funct7 in imm[11:5]; only the SRA variant may set bit 30.
    function automatic logic shift_is_illegal(input logic [1:0] op, input logic use_imm,
                                              input logic [6:0] funct7);
        logic bad_op;
        logic bad_f7;
        bad_op = (op == 2'b10);
        bad_f7 = use_imm && ((op == SHIFT_SRA) ? (funct7 != FUNCT7_SRA) : (funct7 != 7'd0));
        return bad_op | bad_f7;
    endfunction

endpackage

// File: rtl/shift_skid_buffer.sv
// Two-entry valid/ready skid register: head (main) plus one overflow (skid) slot,
// with registered in_ready and a synchronous flush.
module shift_skid_buffer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o
);

    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StOne   = 2'd1;
    localparam logic [1:0] StTwo   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [Width-1:0] main_q, main_d;
    logic [Width-1:0] skid_q, skid_d;
    logic             in_ready_q;
    logic             accept, drain;

    assign accept = in_valid_i & in_ready_q;
    assign drain  = out_valid_o & out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d = StOne;
                    main_d  = in_data_i;
                end
            end
            StOne: begin
                if (accept && !drain) begin
                    state_d = StTwo;
                    skid_d  = in_data_i;
                end else if (accept && drain) begin
                    main_d = in_data_i;
                end else if (drain) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (drain) begin
                    state_d = StOne;
                    main_d  = skid_q;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Data regs may still load under flush; they are don't-care once empty.
        if (flush_i) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StEmpty;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != StTwo);
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (state_q != StEmpty);
    assign out_data_o  = main_q;

endmodule

// File: rtl/shift_operand_stage.sv
// Execute-side operand stage ahead of the shifters: resolves the shift amount,
// flags illegal encodings and buffers entries through a two-deep skid register.
module shift_operand_stage
    import alu_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_rs1_data,
    input  logic [XLEN-1:0]    in_rs2_data,
    input  logic [11:0]        in_imm,
    input  logic               in_use_imm,
    input  logic [1:0]         in_op,
    input  logic [4:0]         in_rd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    operator_1,
    output logic [SHAMT_W-1:0] operator_2,
    output logic [1:0]         out_op,
    output logic [4:0]         out_rd,
    output logic               out_illegal
);

    shift_entry_t in_entry;
    shift_entry_t out_entry;
    logic         unused_rs2_hi;

    assign unused_rs2_hi = ^in_rs2_data[XLEN-1:SHAMT_W];

    always_comb begin
        in_entry.op1     = in_rs1_data;
        in_entry.shamt   = in_use_imm ? in_imm[SHAMT_W-1:0] : in_rs2_data[SHAMT_W-1:0];
        in_entry.op      = in_op;
        in_entry.rd      = in_rd;
        in_entry.illegal = shift_is_illegal(in_op, in_use_imm, in_imm[11:5]);
    end

    shift_skid_buffer #(
        .Width($bits(shift_entry_t))
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_entry),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_entry)
    );

    assign operator_1  = out_entry.op1;
    assign operator_2  = out_entry.shamt;
    assign out_op      = out_entry.op;
    assign out_rd      = out_entry.rd;
    assign out_illegal = out_entry.illegal;

endmodule

// File: doc/shift_operand_stage.md
Name: shift_operand_stage

Overview:
- Execute-side pipeline stage directly upstream of the combinational left/right shifters.
- Captures decoded shift instructions (SLL/SRL/SRA, register or immediate form) and resolves the 5-bit shift amount.
- Presents registered operator_1/operator_2 plus the op select to the shifter bank.
- Valid/ready handshake on both sides, with a 2-entry skid buffer so decode back-pressure is fully registered.

Parameters:
- XLEN, 32, operand width; only 32 is supported.
- SHAMT_W, 5, shift-amount width (log2 XLEN).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- flush  input  1  synchronous pipeline flush (branch mispredict/trap).
- in_valid  input  1  decode offers an instruction.
- in_ready  output  1  stage can accept; registered.
- in_rs1_data  input  32  value to shift.
- in_rs2_data  input  32  register shift amount source; only bits [4:0] are used.
- in_imm  input  12  I-type immediate.
- in_use_imm  input  1  1 = immediate form (SLLI/SRLI/SRAI).
- in_op  input  2  00 SLL, 01 SRL, 11 SRA, 10 reserved.
- in_rd  input  5  destination register tag.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  shifter/writeback consumes the head entry.
- operator_1  output  32  head entry operand.
- operator_2  output  5  head entry shift amount (unsigned).
- out_op  output  2  head entry op.
- out_rd  output  5  head entry rd.
- out_illegal  output  1  head entry is an illegal encoding.

Behaviour:
- Reset (async, asserted): state EMPTY; out_valid=0, in_ready=1, operator_1=0, operator_2=0, out_op=0, out_rd=0, out_illegal=0.
- Handshakes:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - Inputs are sampled only on an input transfer.
- Shift-amount select: operator_2 = in_use_imm ? in_imm[4:0] : in_rs2_data[4:0], resolved at capture time.
- Illegal detection, computed at capture and stored per entry:
  - in_op==10 is illegal.
  - If in_use_imm=1: in_imm[11:5] must be 0000000 for SLL/SRL and 0100000 for SRA; any other value is illegal.
  - Illegal entries still flow through with out_illegal=1; operands are passed unmodified.
- Latency: an instruction accepted at edge N appears with out_valid=1 after edge N (one cycle). There is no combinational path from any input to any output.
- State machine, over main (head) and skid entries:
  - EMPTY: on accept -> ONE (load main).
  - ONE:
    - accept without drain -> TWO (load skid).
    - drain without accept -> EMPTY.
    - accept and drain together -> ONE (main reloaded with the new entry).
  - TWO:
    - in_ready=0.
    - drain -> ONE (skid moves to main).
    - no drain -> hold.
  - Order is strictly FIFO.
  - in_ready is registered = (next_state != TWO).
- Flush:
  - Next state is EMPTY, out_valid=0, in_ready=1.
  - Any input offered in the same cycle is dropped.
  - A simultaneous output transfer still counts as consumed by downstream.
  - Flush beats accept and drain.
- Stall: while out_valid=1 and out_ready=0, all out_* outputs hold stable.
- Reset mid-operation clears both entries immediately; no partial entry survives.
- Datapath registers on an empty entry hold their last values and are don't-care while out_valid=0.

Decomposition:
- Shared package (alu_pkg) holds:
  - Op encodings: SHIFT_SLL=2'b00, SHIFT_SRL=2'b01, SHIFT_SRA=2'b11.
  - FUNCT7_SRA=7'b0100000.
  - An entry struct {op1[31:0], shamt[4:0], op[1:0], rd[4:0], illegal}.
- One sub-module is natural: shift_skid_buffer, a generic 2-entry valid/ready skid register parameterised on payload width. The top level does decode, shamt select and illegal check.

Test Plan:
- Single SLLI: rs1=0x0000_0001, imm=0x01F, use_imm=1, op=00, out_ready=1 -> next cycle out_valid=1, operator_1=0x0000_0001, operator_2=31, out_illegal=0; then out_valid=0.
- Register form masking: rs2=0xFFFF_FFE3, use_imm=0, op=01 -> operator_2=3. SRAI with imm=0x405, op=11 -> operator_2=5, out_illegal=0. SRLI with imm=0x405 -> out_illegal=1.
- Back-pressure: hold out_ready=0 and stream A, B, C with in_valid=1 -> A and B accepted, in_ready=0 in the cycle after B is accepted, C held. Raise out_ready -> outputs A, B, C in order with no loss or duplication, and outputs stay stable while stalled.
- Full throughput: in_valid=1, out_ready=1 for 8 back-to-back ops -> 8 outputs on 8 consecutive cycles, in_ready stays 1.
- Flush while in TWO, with a new op offered the same cycle -> next cycle out_valid=0, in_ready=1, and the offered op never appears.
- Async reset asserted mid-stall between clock edges -> out_valid=0 and in_ready=1 immediately, without waiting for a clock edge. After release, the first accepted op emerges one cycle later.
